// File: rtl/prold_loader_pkg.sv
// Shared state encoding and constants for the program-load transmitter.
package prold_loader_pkg;

  typedef enum logic [2:0] {
    PROLD_S_IDLE   = 3'd0,
    PROLD_S_HEADER = 3'd1,
    PROLD_S_DATA   = 3'd2,
    PROLD_S_FLUSH  = 3'd3,
    PROLD_S_ERROR  = 3'd4,
    PROLD_S_CHECK  = 3'd5
  } prold_state_e;

  localparam int PROLD_FLUSH_CYCLES = 2;
  localparam int PROLD_BYTE_W       = 8;

endpackage

// File: rtl/prold_loader_byte_packer.sv
// Big-endian byte-to-word packer: word_vld_o fires combinationally with the 4th accepted byte.
// Zero latency to the word strobe; never stalls, the caller gates byte_vld_i with its own ready.
module prold_byte_packer
  import prold_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic                    byte_vld_i,
  input  logic [PROLD_BYTE_W-1:0] byte_dat_i,
  output logic                    word_vld_o,
  output logic [31:0]             word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_dat_i};
    end
  end

  assign word_vld_o = byte_vld_i & ~clr_i & (cnt_q == 2'd3);
  assign word_o     = {shift_q, byte_dat_i};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prold_loader.sv
// Program loader: byte stream (length header + words) -> prold writes at consecutive PCs, 1 byte/cycle.
// Optional trailer checksum via PROLD_LOADER_CHECKSUM_EN; all outputs registered.
module prold_loader
  import prold_loader_pkg::*;
#(
  parameter int                  LEN_WORD  = 32,
  parameter int                  LEN_INST  = 32,
  parameter logic [LEN_WORD-1:0] BASE_PC   = '0,
  parameter logic [31:0]         MAX_WORDS = 32'd1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                prold_mode,
  output logic                prold_order,
  output logic [LEN_WORD-1:0] prold_pc,
  output logic [LEN_INST-1:0] prold_data,
  output logic                done,
  output logic                err
);

`ifdef PROLD_LOADER_CHECKSUM_EN
  localparam prold_state_e END_STATE = PROLD_S_CHECK;
`else
  localparam prold_state_e END_STATE = PROLD_S_FLUSH;
`endif

  prold_state_e        state_q, state_d;
  logic [31:0]         rem_q, rem_d;
  logic [LEN_WORD-1:0] pc_q, pc_d;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic                ready_q, ready_d, mode_q, mode_d, order_q, order_d;
  logic                done_q, done_d, err_q, err_d;
  logic [LEN_WORD-1:0] opc_q, opc_d;
  logic [LEN_INST-1:0] odata_q, odata_d;
  logic                accept, pack_vld, clr, word_vld;
  logic [31:0]         word;
`ifdef PROLD_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  assign accept   = byte_valid & ready_q;
  assign pack_vld = accept & ((state_q == PROLD_S_HEADER) | (state_q == PROLD_S_DATA));

  prold_byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (clr),
    .byte_vld_i (pack_vld),
    .byte_dat_i (byte_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    mode_d      = mode_q;
    order_d     = 1'b0;
    opc_d       = opc_q;
    odata_d     = odata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    clr         = 1'b0;
`ifdef PROLD_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      PROLD_S_IDLE, PROLD_S_ERROR: begin
        if (state_q == PROLD_S_ERROR) begin
          mode_d = 1'b0;
          err_d  = 1'b1;
        end
        if (start) begin
          state_d = PROLD_S_HEADER;
          mode_d  = 1'b1;
          err_d   = 1'b0;
          clr     = 1'b1;
`ifdef PROLD_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      PROLD_S_HEADER: if (word_vld) begin
        flush_cnt_d = '0;
        if (word == 32'd0) begin
          state_d = END_STATE;
        end else if (word > MAX_WORDS) begin
          state_d = PROLD_S_ERROR;
          mode_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = PROLD_S_DATA;
          rem_d   = word;
          pc_d    = BASE_PC;
        end
      end
      PROLD_S_DATA: begin
`ifdef PROLD_LOADER_CHECKSUM_EN
        if (accept) sum_d = sum_q + byte_data;
`endif
        if (word_vld) begin
          order_d = 1'b1;
          opc_d   = pc_q;
          odata_d = LEN_INST'(word);
          pc_d    = pc_q + LEN_WORD'(4);
          rem_d   = rem_q - 32'd1;
          if (rem_q == 32'd1) state_d = END_STATE;
        end
      end
`ifdef PROLD_LOADER_CHECKSUM_EN
      PROLD_S_CHECK: if (accept) begin
        if (byte_data == sum_q) begin
          state_d = PROLD_S_FLUSH;
        end else begin
          state_d = PROLD_S_ERROR;
          mode_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
`endif
      PROLD_S_FLUSH: begin
        // Keep fetch parked until the last registered memory write has landed.
        if (flush_cnt_q == 2'(PROLD_FLUSH_CYCLES - 1)) begin
          state_d = PROLD_S_IDLE;
          mode_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: state_d = PROLD_S_IDLE;
    endcase
    ready_d = state_d inside {PROLD_S_HEADER, PROLD_S_DATA, PROLD_S_CHECK};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= PROLD_S_IDLE;
      rem_q       <= '0;
      pc_q        <= '0;
      flush_cnt_q <= '0;
      ready_q     <= 1'b0;
      mode_q      <= 1'b0;
      order_q     <= 1'b0;
      opc_q       <= '0;
      odata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROLD_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      mode_q      <= mode_d;
      order_q     <= order_d;
      opc_q       <= opc_d;
      odata_q     <= odata_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PROLD_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign byte_ready  = ready_q;
  assign prold_mode  = mode_q;
  assign prold_order = order_q;
  assign prold_pc    = opc_q;
  assign prold_data  = odata_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_prold_loader.sv
// Bench for prold_loader: randomized loads checked against a queue-based reference of expected writes.
module tb_prold_loader;

  localparam int          MAXW = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, prold_mode, prold_order, done, err;
  logic [31:0] prold_pc, prold_data;

  prold_loader #(.LEN_WORD(32), .LEN_INST(32), .BASE_PC(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .prold_mode(prold_mode), .prold_order(prold_order),
    .prold_pc(prold_pc), .prold_data(prold_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  logic [31:0] obs_pc[$], obs_data[$];
  int          obs_cyc[$];
  logic        obs_mode[$];
  int          done_cyc[$];
  logic        done_mode[$], done_prev_mode[$];
  logic        prev_mode = 1'b0;

  always @(negedge clk) begin
    if (prold_order === 1'b1) begin
      obs_pc.push_back(prold_pc);
      obs_data.push_back(prold_data);
      obs_cyc.push_back(cyc);
      obs_mode.push_back(prold_mode);
    end
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_mode.push_back(prold_mode);
      done_prev_mode.push_back(prev_mode);
    end
    prev_mode = prold_mode;
  end

  // Reference: words to load, the cycle each 4th byte was accepted, and the end-of-stream accept cycle.
  logic [31:0] wq[$];
  int          exp_cyc[$];
  int          last_acc, end_acc;
  logic [7:0]  csum;

  task automatic clear_obs();
    obs_pc.delete(); obs_data.delete(); obs_cyc.delete(); obs_mode.delete();
    done_cyc.delete(); done_mode.delete(); done_prev_mode.delete(); exp_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      @(negedge clk); rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) break;
      t++;
      if (t > 40) begin
        checks++; errors++;
        $display("FAIL byte_accept: byte_ready low for %0d cycles, required 1", t);
        break;
      end
    end
    last_acc   = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic gap(input int k);
    byte_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) begin
      if (gapmax > 0) gap($urandom_range(gapmax, 0));
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_body(input int gapmax);
    csum = 8'h00;
    send_word(32'(wq.size()), gapmax);
    end_acc = last_acc;
    foreach (wq[i]) begin
      send_word(wq[i], gapmax);
      exp_cyc.push_back(last_acc);
      end_acc = last_acc;
      csum = csum + wq[i][31:24] + wq[i][23:16] + wq[i][15:8] + wq[i][7:0];
    end
`ifdef PROLD_LOADER_CHECKSUM_EN
    send_byte(csum);
    end_acc = last_acc;
`endif
    gap(6);
  endtask

  task automatic check_load(input string name);
    int n;
    n = wq.size();
    checks++;
    if (obs_pc.size() !== n) begin
      errors++; $display("FAIL %s strobe_count: got %0d expected %0d", name, obs_pc.size(), n);
    end
    for (int i = 0; i < n && i < obs_pc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== BASE + 32'(4*i)) begin
        errors++; $display("FAIL %s pc[%0d]: got %h expected %h", name, i, obs_pc[i], BASE + 32'(4*i));
      end
      checks++;
      if (obs_data[i] !== wq[i]) begin
        errors++; $display("FAIL %s data[%0d]: got %h expected %h", name, i, obs_data[i], wq[i]);
      end
      checks++;
      if (obs_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL %s strobe_cycle[%0d]: got %0d expected %0d", name, i, obs_cyc[i], exp_cyc[i]);
      end
      checks++;
      if (obs_mode[i] !== 1'b1) begin
        errors++; $display("FAIL %s mode_at_strobe[%0d]: got %b expected 1", name, i, obs_mode[i]);
      end
    end
    checks++;
    if (done_cyc.size() !== 1) begin
      errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cyc.size());
    end else begin
      checks++;
      if (done_cyc[0] !== end_acc + 2) begin
        errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc[0], end_acc + 2);
      end
      checks++;
      if (done_mode[0] !== 1'b0 || done_prev_mode[0] !== 1'b1) begin
        errors++; $display("FAIL %s mode_fall: got %b->%b expected 1->0", name, done_prev_mode[0], done_mode[0]);
      end
    end
    checks++;
    if (err !== 1'b0 || prold_mode !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got err=%b mode=%b expected 0 0", name, err, prold_mode);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({byte_ready, prold_mode, prold_order, done, err} !== 5'b0 || prold_pc !== 32'h0 || prold_data !== 32'h0) begin
      errors++;
      $display("FAIL %s outputs: got rdy=%b mode=%b order=%b done=%b err=%b pc=%h data=%h expected all 0",
               name, byte_ready, prold_mode, prold_order, done, err, prold_pc, prold_data);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    rstn = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (byte_ready !== 1'b0 || prold_mode !== 1'b0) begin
      errors++; $display("FAIL idle_no_start: got rdy=%b mode=%b expected 0 0", byte_ready, prold_mode);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_two_words();
    wq = '{32'h0000_0013, 32'hDEAD_BEEF};
    clear_obs(); do_start(); load_body(0);
    check_load("two_words");
  endtask

  task automatic test_back_to_back();
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back($urandom());
    clear_obs(); do_start(); load_body(0);
    check_load("back_to_back");
    for (int i = 1; i < exp_cyc.size(); i++) begin
      checks++;
      if (exp_cyc[i] - exp_cyc[i-1] !== 4) begin
        errors++; $display("FAIL b2b_rate[%0d]: got %0d cycles per word expected 4", i, exp_cyc[i] - exp_cyc[i-1]);
      end
    end
  endtask

  task automatic test_zero_len();
    wq.delete();
    clear_obs(); do_start(); load_body(0);
    check_load("zero_len");
  endtask

  task automatic test_overflow();
    clear_obs(); do_start();
    send_word(32'(MAXW + 1), 0);
    gap(3);
    checks++;
    if (err !== 1'b1 || prold_mode !== 1'b0 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL overflow_state: got err=%b mode=%b rdy=%b expected 1 0 0", err, prold_mode, byte_ready);
    end
    checks++;
    if (obs_pc.size() !== 0 || done_cyc.size() !== 0) begin
      errors++; $display("FAIL overflow_quiet: got strobes=%0d dones=%0d expected 0 0", obs_pc.size(), done_cyc.size());
    end
    do_start();
    checks++;
    if (err !== 1'b0 || prold_mode !== 1'b1 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL restart_from_error: got err=%b mode=%b rdy=%b expected 0 1 1", err, prold_mode, byte_ready);
    end
    wq.delete();
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom());
    load_body(0);
    check_load("max_words");
  endtask

  task automatic test_gaps();
    int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int          bi;
    logic [31:0] w;
    w = $urandom();
    wq = '{w};
    bi = 0;
    clear_obs(); do_start();
    send_word(32'd1, 0);
    for (int p = 0; p < 7; p++) begin
      byte_valid = (pat[p] != 0);
      if (pat[p] != 0) byte_data = w[31-8*bi -: 8];
      start = (p == 2);
      @(posedge clk); #1;
      start = 1'b0;
      if (pat[p] != 0) begin last_acc = cyc; bi++; end
    end
    byte_valid = 1'b0;
    exp_cyc.push_back(last_acc);
    end_acc = last_acc;
`ifdef PROLD_LOADER_CHECKSUM_EN
    csum = w[31:24] + w[23:16] + w[15:8] + w[7:0];
    send_byte(csum);
    end_acc = last_acc;
`endif
    gap(6);
    check_load("gaps");
  endtask

  task automatic test_reset_midload();
    clear_obs(); do_start();
    send_word(32'd2, 0);
    send_byte(8'hA5); send_byte(8'h5A);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midload_reset");
    rstn = 1'b1;
    gap(2);
    checks++;
    if (obs_pc.size() !== 0 || done_cyc.size() !== 0) begin
      errors++; $display("FAIL midload_quiet: got strobes=%0d dones=%0d expected 0 0", obs_pc.size(), done_cyc.size());
    end
    wq = '{$urandom(), $urandom()};
    clear_obs(); do_start(); load_body(0);
    check_load("after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) wq.push_back($urandom());
      clear_obs(); do_start(); load_body($urandom_range(3, 0));
      check_load("random");
    end
  endtask

`ifdef PROLD_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq = '{32'h0102_0304};
    clear_obs(); do_start(); load_body(0);
    check_load("checksum_good");
    clear_obs(); do_start();
    send_word(32'd1, 0);
    send_word(32'h0102_0304, 0);
    send_byte(8'h0B);
    gap(4);
    checks++;
    if (err !== 1'b1 || done_cyc.size() !== 0) begin
      errors++; $display("FAIL checksum_bad: got err=%b dones=%0d expected 1 0", err, done_cyc.size());
    end
    checks++;
    if (obs_data.size() !== 1 || (obs_data.size() == 1 && obs_data[0] !== 32'h0102_0304)) begin
      errors++; $display("FAIL checksum_bad_write: got %0d strobes expected 1 of 01020304", obs_data.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_back_to_back();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_reset_midload();
    test_random();
`ifdef PROLD_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
